vid_in_stream_ctrl: RTL and testbench
=====================================

VID_IN_STREAM_CTRL -- requirements
Module: vid_in_stream_ctrl

Interface
REQ-001 Parameter C_LOCK_FRAMES, default 2: number of synchronized vsync rising edges required before streaming is enabled; legal range 1..15.
REQ-002 Parameter C_FLUSH_CYCLES, default 16: consecutive cycles of empty=1 required to end a flush; legal range 1..255.
REQ-003 Parameter C_FLUSH_TIMEOUT, default 4096: maximum cycles spent in FLUSH; legal range 2..65535.
REQ-004 aclk  in  1  the single clock; all logic is in this domain.
REQ-005 rst  in  1  reset, asynchronous assert, active-high.
REQ-006 ctrl_start  in  1  level; 1 = software requests capture, 0 = stop.
REQ-007 vtd_vsync  in  1  vsync from the video-in bridge timing outputs; asynchronous to aclk.
REQ-008 wr_error  in  1  bridge FIFO write-overflow flag; asynchronous to aclk.
REQ-009 empty  in  1  bridge FIFO empty flag; aclk domain.
REQ-010 m_axis_video_tvalid, m_axis_video_tready, m_axis_video_tuser  in  1 each  monitor taps on the bridge AXI4-Stream output.
REQ-011 axis_enable  out  1  drives the bridge axis_enable input.
REQ-012 locked  out  1  1 only while in RUN.
REQ-013 state  out  2  IDLE=0, WAIT_SYNC=1, RUN=2, FLUSH=3.
REQ-014 frame_count  out  16  count of accepted start-of-frame beats.
REQ-015 err_count  out  8  count of overflow and flush-timeout events.

Function
REQ-016 vtd_vsync and wr_error shall each pass through a 2-FF synchronizer, reset to 0, followed by a registered rising-edge detector; an input rising edge produces a 1-cycle pulse exactly 3 aclk cycles later.
REQ-017 All outputs shall be registered; axis_enable and locked shall be decoded from the registered state (axis_enable=1 iff state=RUN).
REQ-018 IDLE: when ctrl_start=1, go to WAIT_SYNC next cycle and clear the sync counter.
REQ-019 WAIT_SYNC: each vsync pulse increments a 4-bit sync counter; on the pulse that makes it equal C_LOCK_FRAMES, go to RUN next cycle; ctrl_start=0 returns to IDLE with priority over the vsync pulse.
REQ-020 RUN: each cycle with tvalid&tready&tuser=1 increments frame_count; frame_count wraps 0xFFFF->0x0000 and is cleared only by rst.
REQ-021 RUN: a wr_error pulse or ctrl_start=0 shall cause transition to FLUSH next cycle; a wr_error pulse increments err_count even when it coincides with ctrl_start=0.
REQ-022 err_count shall saturate at 0xFF; wr_error pulses outside RUN shall not be counted.
REQ-023 FLUSH: the empty-run counter increments while empty=1 and clears whenever empty=0; the timeout counter increments every cycle; both counters clear on entry.
REQ-024 FLUSH exit: when the empty-run count reaches C_FLUSH_CYCLES, or the timeout count reaches C_FLUSH_TIMEOUT, go to WAIT_SYNC if ctrl_start=1, else IDLE.
REQ-025 Timeout exit shall increment err_count (saturating); if both exit conditions occur in the same cycle, empty-run completion takes precedence and err_count is unchanged.
REQ-026 Entry into WAIT_SYNC from FLUSH shall clear the sync counter, so a full C_LOCK_FRAMES relock is required.
REQ-027 A frame_count increment coinciding with the RUN->FLUSH decision cycle shall still be counted.

Reset
REQ-028 rst=1 shall immediately force state=IDLE, axis_enable=0, locked=0, frame_count=0, err_count=0, and clear all synchronizers and counters, including mid-RUN and mid-FLUSH.
REQ-029 After rst deasserts, the first state change shall be no earlier than the first rising aclk edge on which ctrl_start=1 is sampled.

Verification
REQ-030 ctrl_start=1, 2 vsync pulses -> state 1, then 2; axis_enable=1 three aclk cycles after the second vsync edge plus 1 cycle; locked=1.
REQ-031 RUN, 3 accepted tuser beats plus 1 tuser beat with tready=0 -> frame_count=3; preload to 0xFFFF plus 1 beat -> 0x0000.
REQ-032 RUN, wr_error pulse, empty held 1 -> FLUSH with axis_enable=0 after 4 cycles; returns to WAIT_SYNC after 16 empty cycles; err_count=1.
REQ-033 FLUSH with empty held 0 -> exit after 4096 cycles, err_count increments; 300 forced errors -> err_count=0xFF.
REQ-034 ctrl_start=0 and wr_error edge in the same cycle in RUN -> FLUSH, err_count+1, then IDLE.
REQ-035 rst asserted mid-FLUSH -> all outputs 0 asynchronously; no state change until ctrl_start=1.

Source files
------------

// File: rtl/vid_in_stream_ctrl.sv
// vid_in_stream_ctrl: capture controller for a video-in to AXI4-Stream bridge.
// It waits for C_LOCK_FRAMES vsync edges before it enables streaming. It counts
// start-of-frame beats while streaming. After an overflow or a stop request it
// flushes the bridge FIFO, and it counts overflow and flush-timeout events.
module vid_in_stream_ctrl #(
    parameter int unsigned C_LOCK_FRAMES   = 2,
    parameter int unsigned C_FLUSH_CYCLES  = 16,
    parameter int unsigned C_FLUSH_TIMEOUT = 4096
) (
    input  logic        aclk,
    input  logic        rst,
    input  logic        ctrl_start,
    input  logic        vtd_vsync,
    input  logic        wr_error,
    input  logic        empty,
    input  logic        m_axis_video_tvalid,
    input  logic        m_axis_video_tready,
    input  logic        m_axis_video_tuser,
    output logic        axis_enable,
    output logic        locked,
    output logic [1:0]  state,
    output logic [15:0] frame_count,
    output logic [7:0]  err_count
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_SYNC = 2'd1,
        ST_RUN       = 2'd2,
        ST_FLUSH     = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        vs_meta_q, vs_meta_d, vs_sync_q, vs_sync_d;
    logic        vs_prev_q, vs_prev_d, vs_pulse_q, vs_pulse_d;
    logic        we_meta_q, we_meta_d, we_sync_q, we_sync_d;
    logic        we_prev_q, we_prev_d, we_pulse_q, we_pulse_d;
    logic [3:0]  sync_cnt_q, sync_cnt_d;
    logic [7:0]  empty_cnt_q, empty_cnt_d, empty_next;
    logic [15:0] tmo_cnt_q, tmo_cnt_d, tmo_next;
    logic [15:0] frame_count_q, frame_count_d;
    logic [7:0]  err_count_q, err_count_d;
    logic        axis_enable_q, axis_enable_d;
    logic        locked_q, locked_d;
    logic        err_inc;

    // Two-stage synchronizers followed by registered rising-edge detectors
    always_comb begin
        vs_meta_d  = vtd_vsync;
        vs_sync_d  = vs_meta_q;
        vs_prev_d  = vs_sync_q;
        vs_pulse_d = vs_sync_q & ~vs_prev_q;
        we_meta_d  = wr_error;
        we_sync_d  = we_meta_q;
        we_prev_d  = we_sync_q;
        we_pulse_d = we_sync_q & ~we_prev_q;
    end

    // Next-state, counter and output decode
    always_comb begin
        state_d       = state_q;
        sync_cnt_d    = sync_cnt_q;
        empty_cnt_d   = empty_cnt_q;
        tmo_cnt_d     = tmo_cnt_q;
        frame_count_d = frame_count_q;
        err_count_d   = err_count_q;
        err_inc       = 1'b0;
        empty_next    = empty ? empty_cnt_q + 8'd1 : 8'd0;
        tmo_next      = tmo_cnt_q + 16'd1;

        unique case (state_q)
            ST_IDLE: begin
                if (ctrl_start) begin
                    state_d    = ST_WAIT_SYNC;
                    sync_cnt_d = '0;
                end
            end
            ST_WAIT_SYNC: begin
                if (!ctrl_start) begin
                    state_d = ST_IDLE;
                end else if (vs_pulse_q) begin
                    sync_cnt_d = sync_cnt_q + 4'd1;
                    if (sync_cnt_q + 4'd1 == 4'(C_LOCK_FRAMES)) begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (m_axis_video_tvalid && m_axis_video_tready && m_axis_video_tuser) begin
                    frame_count_d = frame_count_q + 16'd1;
                end
                err_inc = we_pulse_q;
                if (we_pulse_q || !ctrl_start) begin
                    state_d     = ST_FLUSH;
                    empty_cnt_d = '0;
                    tmo_cnt_d   = '0;
                end
            end
            ST_FLUSH: begin
                empty_cnt_d = empty_next;
                tmo_cnt_d   = tmo_next;
                // Completing the empty run wins over a timeout in the same cycle
                if (empty_next == 8'(C_FLUSH_CYCLES)) begin
                    state_d    = ctrl_start ? ST_WAIT_SYNC : ST_IDLE;
                    sync_cnt_d = '0;
                end else if (tmo_next == 16'(C_FLUSH_TIMEOUT)) begin
                    state_d    = ctrl_start ? ST_WAIT_SYNC : ST_IDLE;
                    sync_cnt_d = '0;
                    err_inc    = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (err_inc && (err_count_q != 8'hFF)) begin
            err_count_d = err_count_q + 8'd1;
        end

        axis_enable_d = (state_d == ST_RUN);
        locked_d      = (state_d == ST_RUN);
    end

    // State, counter and output registers
    always_ff @(posedge aclk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            vs_meta_q     <= 1'b0;
            vs_sync_q     <= 1'b0;
            vs_prev_q     <= 1'b0;
            vs_pulse_q    <= 1'b0;
            we_meta_q     <= 1'b0;
            we_sync_q     <= 1'b0;
            we_prev_q     <= 1'b0;
            we_pulse_q    <= 1'b0;
            sync_cnt_q    <= '0;
            empty_cnt_q   <= '0;
            tmo_cnt_q     <= '0;
            frame_count_q <= '0;
            err_count_q   <= '0;
            axis_enable_q <= 1'b0;
            locked_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            vs_meta_q     <= vs_meta_d;
            vs_sync_q     <= vs_sync_d;
            vs_prev_q     <= vs_prev_d;
            vs_pulse_q    <= vs_pulse_d;
            we_meta_q     <= we_meta_d;
            we_sync_q     <= we_sync_d;
            we_prev_q     <= we_prev_d;
            we_pulse_q    <= we_pulse_d;
            sync_cnt_q    <= sync_cnt_d;
            empty_cnt_q   <= empty_cnt_d;
            tmo_cnt_q     <= tmo_cnt_d;
            frame_count_q <= frame_count_d;
            err_count_q   <= err_count_d;
            axis_enable_q <= axis_enable_d;
            locked_q      <= locked_d;
        end
    end

    assign state       = state_q;
    assign axis_enable = axis_enable_q;
    assign locked      = locked_q;
    assign frame_count = frame_count_q;
    assign err_count   = err_count_q;

endmodule

// File: tb/tb_vid_in_stream_ctrl.sv
// Self-checking bench for vid_in_stream_ctrl (default parameters).
// Input vector bit order: {ctrl_start, vsync, wr_error, empty, tvalid, tready, tuser}.
module tb_vid_in_stream_ctrl;

    logic        aclk = 1'b0;
    logic        rst;
    logic        ctrl_start, vtd_vsync, wr_error, empty;
    logic        tvalid, tready, tuser;
    logic        axis_enable, locked;
    logic [1:0]  state;
    logic [15:0] frame_count;
    logic [7:0]  err_count;

    vid_in_stream_ctrl #(
        .C_LOCK_FRAMES  (2),
        .C_FLUSH_CYCLES (16),
        .C_FLUSH_TIMEOUT(4096)
    ) dut (
        .aclk               (aclk),
        .rst                (rst),
        .ctrl_start         (ctrl_start),
        .vtd_vsync          (vtd_vsync),
        .wr_error           (wr_error),
        .empty              (empty),
        .m_axis_video_tvalid(tvalid),
        .m_axis_video_tready(tready),
        .m_axis_video_tuser (tuser),
        .axis_enable        (axis_enable),
        .locked             (locked),
        .state              (state),
        .frame_count        (frame_count),
        .err_count          (err_count)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        string       tag;
        logic [6:0]  in;
        logic        chk;
        logic [1:0]  st;
        logic [15:0] fc;
        logic [7:0]  ec;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic vec_t mk(input string tag, input logic [6:0] in, input logic chk,
                                input logic [1:0] st, input logic [15:0] fc, input logic [7:0] ec);
        vec_t v;
        v.tag = tag; v.in = in; v.chk = chk; v.st = st; v.fc = fc; v.ec = ec;
        return v;
    endfunction

    task automatic compare(input vec_t e);
        logic exp_en;
        exp_en = (e.st == 2'd2);
        n_vec++;
        if (state !== e.st || axis_enable !== exp_en || locked !== exp_en ||
            frame_count !== e.fc || err_count !== e.ec) begin
            n_err++;
            $display("FAIL %s: got state=%0d en=%b lk=%b fc=%h ec=%h, want state=%0d en=%b lk=%b fc=%h ec=%h",
                     e.tag, state, axis_enable, locked, frame_count, err_count,
                     e.st, exp_en, exp_en, e.fc, e.ec);
        end
    endtask

    task automatic check_head();
        vec_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.chk) compare(e);
        end
    endtask

    task automatic drive(input logic [6:0] in);
        {ctrl_start, vtd_vsync, wr_error, empty, tvalid, tready, tuser} = in;
    endtask

    task automatic apply(input vec_t v);
        @(negedge aclk);
        check_head();
        drive(v.in);
        sb.push_back(v);
    endtask

    task automatic run(input string tag, input logic [6:0] in, input logic chk,
                       input logic [1:0] st, input logic [15:0] fc, input logic [7:0] ec);
        apply(mk(tag, in, chk, st, fc, ec));
    endtask

    task automatic drain();
        @(negedge aclk);
        check_head();
    endtask

    // Two vsync pulses from WAIT_SYNC with ctrl_start held; RUN after the second
    task automatic lock(input string tag, input logic [15:0] fc, input logic [7:0] ec);
        for (int p = 0; p < 2; p++) begin
            run(tag, 7'b1100000, 1'b0, 2'd0, fc, ec);
            run(tag, 7'b1000000, 1'b0, 2'd0, fc, ec);
            run(tag, 7'b1000000, 1'b0, 2'd0, fc, ec);
            run(tag, 7'b1000000, 1'b1, (p == 0) ? 2'd1 : 2'd2, fc, ec);
        end
    endtask

    // Overflow edge in RUN; FLUSH three cycles later with the error counted
    task automatic overflow(input string tag, input logic [15:0] fc, input logic [7:0] ec_after);
        run(tag, 7'b1010000, 1'b0, 2'd0, fc, ec_after);
        run(tag, 7'b1001000, 1'b0, 2'd0, fc, ec_after);
        run(tag, 7'b1001000, 1'b0, 2'd0, fc, ec_after);
        run(tag, 7'b1001000, 1'b1, 2'd3, fc, ec_after);
    endtask

    logic [7:0] ec_exp;

    initial begin
        rst = 1'b1;
        drive(7'b0000000);
        #1;
        compare(mk("reset", 7'b0, 1'b1, 2'd0, 16'd0, 8'd0));
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        rst = 1'b0;

        // Main table: idle immunity, lock, frame counting, overflow flush
        tbl.push_back(mk("idle0", 7'b0000000, 1'b1, 2'd0, 16'd0, 8'd0));
        tbl.push_back(mk("idle_vs", 7'b0100000, 1'b1, 2'd0, 16'd0, 8'd0));
        tbl.push_back(mk("idle_we", 7'b0010000, 1'b1, 2'd0, 16'd0, 8'd0));
        tbl.push_back(mk("idle3", 7'b0000000, 1'b1, 2'd0, 16'd0, 8'd0));
        tbl.push_back(mk("idle4", 7'b0000000, 1'b1, 2'd0, 16'd0, 8'd0));
        tbl.push_back(mk("start", 7'b1000000, 1'b1, 2'd1, 16'd0, 8'd0));
        tbl.push_back(mk("vs1", 7'b1100000, 1'b1, 2'd1, 16'd0, 8'd0));
        for (int i = 0; i < 3; i++) tbl.push_back(mk("vs1w", 7'b1000000, 1'b1, 2'd1, 16'd0, 8'd0));
        tbl.push_back(mk("vs2", 7'b1100000, 1'b1, 2'd1, 16'd0, 8'd0));
        tbl.push_back(mk("vs2w", 7'b1000000, 1'b1, 2'd1, 16'd0, 8'd0));
        tbl.push_back(mk("vs2w", 7'b1000000, 1'b1, 2'd1, 16'd0, 8'd0));
        tbl.push_back(mk("lock", 7'b1000000, 1'b1, 2'd2, 16'd0, 8'd0));
        tbl.push_back(mk("sof1", 7'b1000111, 1'b1, 2'd2, 16'd1, 8'd0));
        tbl.push_back(mk("sof2", 7'b1000111, 1'b1, 2'd2, 16'd2, 8'd0));
        tbl.push_back(mk("sof_nordy", 7'b1000101, 1'b1, 2'd2, 16'd2, 8'd0));
        tbl.push_back(mk("sof3", 7'b1000111, 1'b1, 2'd2, 16'd3, 8'd0));
        tbl.push_back(mk("beat_nouser", 7'b1000110, 1'b1, 2'd2, 16'd3, 8'd0));
        tbl.push_back(mk("we_edge", 7'b1011000, 1'b1, 2'd2, 16'd3, 8'd0));
        tbl.push_back(mk("we_sync", 7'b1001000, 1'b1, 2'd2, 16'd3, 8'd0));
        tbl.push_back(mk("we_sync", 7'b1001000, 1'b1, 2'd2, 16'd3, 8'd0));
        tbl.push_back(mk("flush_sof", 7'b1001111, 1'b1, 2'd3, 16'd4, 8'd1));
        for (int i = 0; i < 5; i++) tbl.push_back(mk("fl_e", 7'b1001000, 1'b1, 2'd3, 16'd4, 8'd1));
        tbl.push_back(mk("fl_ne", 7'b1000000, 1'b1, 2'd3, 16'd4, 8'd1));
        for (int i = 0; i < 15; i++) tbl.push_back(mk("fl_e", 7'b1001000, 1'b1, 2'd3, 16'd4, 8'd1));
        tbl.push_back(mk("fl_done", 7'b1001000, 1'b1, 2'd1, 16'd4, 8'd1));

        for (int i = 0; i < tbl.size(); i++) begin
            tbl[i].tag = $sformatf("%s[%0d]", tbl[i].tag, i);
            apply(tbl[i]);
        end

        // Full relock after flush, then frame counter wrap
        lock("relock", 16'd4, 8'd1);
        run("run_idle", 7'b1000000, 1'b1, 2'd2, 16'd4, 8'd1);
        @(negedge aclk);
        check_head();
        force dut.frame_count_q = 16'hFFFF;
        #1;
        release dut.frame_count_q;
        drive(7'b1000111);
        sb.push_back(mk("fc_wrap", 7'b1000111, 1'b1, 2'd2, 16'h0000, 8'd1));
        run("fc_after_wrap", 7'b1000111, 1'b1, 2'd2, 16'd1, 8'd1);

        // Stop request coinciding with the overflow pulse
        run("stop_we", 7'b1010000, 1'b0, 2'd0, 16'd1, 8'd1);
        run("stop_we", 7'b1000000, 1'b0, 2'd0, 16'd1, 8'd1);
        run("stop_we", 7'b1000000, 1'b0, 2'd0, 16'd1, 8'd1);
        run("stop_and_we", 7'b0000000, 1'b1, 2'd3, 16'd1, 8'd2);
        for (int i = 1; i <= 16; i++)
            run("stop_flush", 7'b0001000, 1'b1, (i == 16) ? 2'd0 : 2'd3, 16'd1, 8'd2);

        // Pure timeout; an overflow edge inside FLUSH is not counted
        run("restart", 7'b1000000, 1'b1, 2'd1, 16'd1, 8'd2);
        lock("lock_to", 16'd1, 8'd2);
        run("to_enter", 7'b0000000, 1'b1, 2'd3, 16'd1, 8'd2);
        for (int i = 1; i <= 4096; i++)
            run("timeout", (i == 1) ? 7'b1010000 : 7'b1000000, (i >= 4094),
                (i == 4096) ? 2'd1 : 2'd3, 16'd1, (i == 4096) ? 8'd3 : 8'd2);

        // Empty run completes on the very cycle the timeout expires
        lock("lock_tie", 16'd1, 8'd3);
        run("tie_enter", 7'b0000000, 1'b1, 2'd3, 16'd1, 8'd3);
        for (int i = 1; i <= 4096; i++)
            run("tie", {1'b1, 2'b00, (i > 4080), 3'b000}, (i >= 4095),
                (i == 4096) ? 2'd1 : 2'd3, 16'd1, 8'd3);

        // Repeated overflows drive err_count into saturation
        ec_exp = 8'd3;
        for (int k = 0; k < 300; k++) begin
            lock("sat_lock", 16'd1, ec_exp);
            if (ec_exp != 8'hFF) ec_exp = ec_exp + 8'd1;
            overflow("sat_ovf", 16'd1, ec_exp);
            for (int i = 1; i <= 16; i++)
                run("sat_flush", 7'b1001000, (i == 16), 2'd1, 16'd1, ec_exp);
        end
        run("sat_final", 7'b1000000, 1'b1, 2'd1, 16'd1, 8'hFF);

        // Asynchronous reset in the middle of FLUSH
        lock("lock_rst", 16'd1, 8'hFF);
        overflow("ovf_sat", 16'd1, 8'hFF);
        for (int i = 0; i < 3; i++) run("mid_flush", 7'b1000000, 1'b1, 2'd3, 16'd1, 8'hFF);
        drain();
        @(posedge aclk);
        #2;
        rst = 1'b1;
        #1;
        compare(mk("rst_async", 7'b0, 1'b1, 2'd0, 16'd0, 8'd0));
        @(negedge aclk);
        rst = 1'b0;
        drive(7'b0000000);
        run("post_rst", 7'b0100000, 1'b1, 2'd0, 16'd0, 8'd0);
        run("post_rst", 7'b0010000, 1'b1, 2'd0, 16'd0, 8'd0);
        run("post_rst", 7'b0101111, 1'b1, 2'd0, 16'd0, 8'd0);
        run("post_rst", 7'b0000000, 1'b1, 2'd0, 16'd0, 8'd0);
        run("post_rst", 7'b0000000, 1'b1, 2'd0, 16'd0, 8'd0);
        run("post_rst_start", 7'b1000000, 1'b1, 2'd1, 16'd0, 8'd0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
